// File: rtl/uart_mmio_sequencer.sv
// uart_mmio_sequencer: owns the UART MMIO port, programs baud/ctrl,
// then polls STATUS to move bytes between the streams and the UART.
module uart_mmio_sequencer #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter logic [15:0] BAUDDIV   = 16'd433,
  parameter int          TX_DEPTH  = 8,
  parameter int          RX_DEPTH  = 8,
  parameter int          POLL_GAP  = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cfg_reinit,
  input  logic [15:0] cfg_bauddiv,
  input  logic        cfg_loopback,
  output logic        bus_as_l,
  output logic        bus_we_l,
  output logic [31:0] bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic        init_done,
  output logic        err_overrun,
  output logic        err_frame,
  input  logic        err_clr
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int TCW = $clog2(TX_DEPTH + 1);
  localparam int RCW = $clog2(RX_DEPTH + 1);
  localparam logic [TCW-1:0] TX_FULL = TCW'(TX_DEPTH);
  localparam logic [RCW-1:0] RX_FULL = RCW'(RX_DEPTH);

  typedef enum logic [2:0] {
    INIT_BL, INIT_BH, INIT_CTRL, POLL,
    ERR_CLR, RX_RD, TX_WR, WAIT
  } state_t;

  state_t state, ns;
  logic live, in_init, reinit;
  logic [15:0] div;
  logic lb;
  logic [7:0] gap;
  logic n_as, n_we;
  logic [2:0] n_off;
  logic [7:0] n_wd;

  logic [7:0] tx_mem [TX_DEPTH];
  logic [TAW-1:0] tx_rd, tx_wr;
  logic [TCW-1:0] tx_count;
  logic tx_push, tx_pop;

  logic [7:0] rx_mem [RX_DEPTH];
  logic [RAW-1:0] rx_rd, rx_wr;
  logic [RCW-1:0] rx_count;
  logic rx_push, rx_pop;

  assign in_init  = state inside {INIT_BL, INIT_BH, INIT_CTRL};
  assign reinit   = cfg_reinit & ~in_init;
  assign tx_ready = tx_count < TX_FULL;
  assign rx_valid = rx_count != '0;
  assign rx_data  = rx_mem[rx_rd];
  assign tx_push  = tx_valid & tx_ready;
  assign tx_pop   = ns == TX_WR;
  assign rx_push  = state == RX_RD;
  assign rx_pop   = rx_valid & rx_ready;

  // Next state; POLL decodes STATUS from the read in flight.
  always_comb begin
    ns = state;
    case (state)
      INIT_BL:   ns = INIT_BH;
      INIT_BH:   ns = INIT_CTRL;
      INIT_CTRL: ns = POLL;
      POLL: begin
        if (bus_rdata[3] | bus_rdata[2])
          ns = ERR_CLR;
        else if (bus_rdata[1] && rx_count < RX_FULL)
          ns = RX_RD;
        else if (bus_rdata[0] && tx_count != '0)
          ns = TX_WR;
        else if (POLL_GAP > 0)
          ns = WAIT;
        else
          ns = POLL;
      end
      WAIT:      ns = (gap == 8'd0) ? POLL : WAIT;
      default:   ns = POLL;
    endcase
    if (reinit) ns = INIT_BL;
    if (!live) ns = INIT_BL;
  end

  // Bus access that the next state presents for one cycle.
  always_comb begin
    n_as  = 1'b1;
    n_we  = 1'b1;
    n_off = 3'd0;
    n_wd  = 8'h00;
    case (ns)
      INIT_BL: begin
        n_as = 1'b0; n_we = 1'b0; n_off = 3'd2;
        n_wd = reinit ? cfg_bauddiv[7:0] : div[7:0];
      end
      INIT_BH: begin
        n_as = 1'b0; n_we = 1'b0; n_off = 3'd3;
        n_wd = div[15:8];
      end
      INIT_CTRL: begin
        n_as = 1'b0; n_we = 1'b0; n_off = 3'd4;
        n_wd = {3'b000, 1'b1, 1'b1, lb, 1'b1, 1'b1};
      end
      POLL: begin
        n_as = 1'b0; n_off = 3'd1;
      end
      ERR_CLR: begin
        n_as = 1'b0; n_we = 1'b0; n_off = 3'd1;
        n_wd = {4'b0000, bus_rdata[3], bus_rdata[2], 2'b00};
      end
      RX_RD: begin
        n_as = 1'b0; n_off = 3'd0;
      end
      TX_WR: begin
        n_as = 1'b0; n_we = 1'b0; n_off = 3'd0;
        n_wd = tx_mem[tx_rd];
      end
      default: ;
    endcase
  end

  // Sequencer state, registered bus outputs, config and error flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= INIT_BL;
      live        <= 1'b0;
      bus_as_l    <= 1'b1;
      bus_we_l    <= 1'b1;
      bus_addr    <= BASE_ADDR;
      bus_wdata   <= 8'h00;
      init_done   <= 1'b0;
      err_overrun <= 1'b0;
      err_frame   <= 1'b0;
      div         <= BAUDDIV;
      lb          <= 1'b0;
      gap         <= 8'd0;
    end else begin
      live      <= 1'b1;
      state     <= ns;
      bus_as_l  <= n_as;
      bus_we_l  <= n_we;
      bus_addr  <= BASE_ADDR + 32'(n_off);
      bus_wdata <= n_wd;
      if (reinit) begin
        div <= cfg_bauddiv;
        lb  <= cfg_loopback;
      end
      if (ns == INIT_BL)
        init_done <= 1'b0;
      else if (state == INIT_CTRL)
        init_done <= 1'b1;
      if (ns == WAIT && state != WAIT)
        gap <= 8'(POLL_GAP - 1);
      else if (state == WAIT && gap != 8'd0)
        gap <= gap - 8'd1;
      err_frame <= (err_frame & ~err_clr)
                 | (state == ERR_CLR && bus_wdata[3]);
      err_overrun <= (err_overrun & ~err_clr)
                   | (state == ERR_CLR && bus_wdata[2]);
    end
  end

  // FIFO pointers and occupancy counts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_rd    <= '0;
      tx_wr    <= '0;
      tx_count <= '0;
      rx_rd    <= '0;
      rx_wr    <= '0;
      rx_count <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + TAW'(1);
      if (tx_pop)  tx_rd <= tx_rd + TAW'(1);
      tx_count <= tx_count + TCW'(tx_push) - TCW'(tx_pop);
      if (rx_push) rx_wr <= rx_wr + RAW'(1);
      if (rx_pop)  rx_rd <= rx_rd + RAW'(1);
      rx_count <= rx_count + RCW'(rx_push) - RCW'(rx_pop);
    end
  end

  // FIFO storage; contents are don't-care until pointed at.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= tx_data;
    if (rx_push) rx_mem[rx_wr] <= bus_rdata;
  end

endmodule

// File: tb/tb_uart_mmio_sequencer.sv
// tb_uart_mmio_sequencer: loopback UART model plus scoreboards for
// register writes, TX data writes and the RX byte stream.
module tb_uart_mmio_sequencer;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic cfg_reinit = 1'b0;
  logic [15:0] cfg_bauddiv = 16'h0000;
  logic cfg_loopback = 1'b0;
  logic bus_as_l, bus_we_l;
  logic [31:0] bus_addr;
  logic [7:0] bus_wdata, bus_rdata;
  logic tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_ready, rx_valid;
  logic [7:0] rx_data;
  logic rx_ready = 1'b1;
  logic init_done, err_overrun, err_frame;
  logic err_clr = 1'b0;

  uart_mmio_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_reinit(cfg_reinit), .cfg_bauddiv(cfg_bauddiv),
    .cfg_loopback(cfg_loopback),
    .bus_as_l(bus_as_l), .bus_we_l(bus_we_l),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .init_done(init_done), .err_overrun(err_overrun),
    .err_frame(err_frame), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Expected traffic: {offset,data} register writes, TX bytes, RX bytes.
  logic [15:0] ctl_exp [$];
  logic [7:0] tx_exp [$];
  logic [7:0] rx_exp [$];

  // UART model: one-byte RX holding register, loopback after 10 bit times.
  logic [7:0] m_rx, m_txb, m_ctrl;
  logic [15:0] m_div;
  logic m_full, m_ovr, m_frc;
  int m_busy;
  logic blk = 1'b0;
  logic inj = 1'b0;
  logic [7:0] inj_b = 8'h00;
  logic tx_idle, rd0, wr_any;
  logic [7:0] m_st;

  assign tx_idle = (m_busy == 0) && !blk;
  assign m_st = m_frc ? 8'h0B : {5'b0, m_ovr, m_full, tx_idle};
  assign rd0 = !bus_as_l && bus_we_l && bus_addr == BASE;
  assign wr_any = !bus_as_l && !bus_we_l;

  always_comb begin
    bus_rdata = 8'h00;
    if (!bus_as_l && bus_we_l) begin
      if (bus_addr == BASE) bus_rdata = m_rx;
      else if (bus_addr == BASE + 32'd1) bus_rdata = m_st;
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_rx <= 8'h00; m_txb <= 8'h00; m_ctrl <= 8'h00;
      m_div <= 16'h0000; m_full <= 1'b0; m_ovr <= 1'b0;
      m_frc <= 1'b0; m_busy <= 0;
    end else begin
      if (rd0) m_full <= 1'b0;
      if (m_busy > 1) m_busy <= m_busy - 1;
      else if (m_busy == 1) begin
        m_busy <= 0;
        if (m_ctrl[2]) begin
          if (m_full && !rd0) m_ovr <= 1'b1;
          else begin
            m_rx <= m_txb;
            m_full <= 1'b1;
          end
        end
      end
      if (wr_any) begin
        case (bus_addr - BASE)
          32'd0: begin
            m_txb <= bus_wdata;
            m_busy <= 10 * (int'(m_div) + 1);
          end
          32'd1: begin
            if (bus_wdata[2]) m_ovr <= 1'b0;
            if (bus_wdata[3]) m_frc <= 1'b0;
          end
          32'd2: m_div[7:0] <= bus_wdata;
          32'd3: m_div[15:8] <= bus_wdata;
          32'd4: begin
            m_ctrl <= bus_wdata;
            if (bus_wdata[3]) m_full <= 1'b0;
            if (bus_wdata[4]) begin
              m_ovr <= 1'b0;
              m_frc <= 1'b0;
            end
          end
          default: ;
        endcase
      end
      if (inj) begin
        m_rx <= inj_b;
        m_full <= 1'b1;
        m_frc <= 1'b1;
      end
    end
  end

  // Monitor: scoreboard pops on every bus write and RX handshake.
  int rx_occ = 0;
  logic frc_ph = 1'b0;
  logic [31:0] off;
  logic [15:0] e;

  always @(negedge clk) begin
    off = bus_addr - BASE;
    if (!reset_n) rx_occ = 0;
    else begin
      chk("rx_valid", rx_valid, rx_occ > 0);
      if (rx_valid && rx_ready) begin
        e = rx_exp.size() > 0 ? {8'h00, rx_exp.pop_front()} : 16'hFFFF;
        chk("rx_data", {8'h00, rx_data}, e);
        rx_occ--;
      end
      if (wr_any) begin
        if (off == 32'd0) begin
          e = tx_exp.size() > 0 ? {8'h00, tx_exp.pop_front()} : 16'hFFFF;
          chk("tx_write", {8'h00, bus_wdata}, e);
          chk("tx_idle_at_write", tx_idle, 1);
        end else begin
          e = ctl_exp.size() > 0 ? ctl_exp.pop_front() : 16'hFFFF;
          chk("reg_write", {off[7:0], bus_wdata}, e);
        end
      end
      if (rd0) begin
        chk("rx_rd_space", rx_occ < 8, 1);
        if (frc_ph) chk("err_clr_first", ctl_exp.size(), 0);
        rx_occ++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data = b;
    while (!tx_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("push_timeout", tx_ready, 1);
    step();
    tx_valid = 1'b0;
    tx_exp.push_back(b);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((tx_exp.size() + rx_exp.size()) > 0 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_drain"}, tx_exp.size() + rx_exp.size(), 0);
  endtask

  task automatic wait_init(input string nm);
    int n = 0;
    while (!init_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_init_done"}, init_done, 1);
  endtask

  task automatic pulse_err_clr();
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  task automatic reinit(input logic [15:0] d);
    step();
    cfg_reinit = 1'b1;
    cfg_bauddiv = d;
    cfg_loopback = 1'b1;
    ctl_exp.push_back({8'd2, d[7:0]});
    ctl_exp.push_back({8'd3, d[15:8]});
    ctl_exp.push_back({8'd4, 8'h1F});
    step();
    cfg_reinit = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run still active, want finished");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    logic [7:0] bs [10];
    int n;
    repeat (3) @(negedge clk);
    chk("rst_as_l", bus_as_l, 1);
    chk("rst_we_l", bus_we_l, 1);
    chk("rst_addr", bus_addr, BASE);
    chk("rst_wdata", bus_wdata, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_err", {err_overrun, err_frame}, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_valid", rx_valid, 0);

    ctl_exp.push_back({8'd2, 8'hB1});
    ctl_exp.push_back({8'd3, 8'h01});
    ctl_exp.push_back({8'd4, 8'h1B});
    step();
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("ctrl_cycle_addr", bus_addr, BASE + 32'd4);
    chk("ctrl_cycle_done", init_done, 0);
    @(negedge clk);
    chk("first_poll_done", init_done, 1);
    chk("first_poll_acc", {bus_as_l, bus_we_l, bus_addr},
        {2'b01, BASE + 32'd1});
    repeat (5) @(negedge clk);

    reinit(16'd3);
    @(negedge clk);
    chk("reinit_clears_done", init_done, 0);
    wait_init("lb");
    push(8'h55); rx_exp.push_back(8'h55);
    push(8'hA3); rx_exp.push_back(8'hA3);
    push(8'h0F); rx_exp.push_back(8'h0F);
    drain("three");
    chk("three_err", {err_overrun, err_frame}, 0);

    step();
    blk = 1'b1;
    repeat (3) step();
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      push(b);
      rx_exp.push_back(b);
    end
    @(negedge clk);
    chk("tx_full_ready", tx_ready, 0);
    step();
    blk = 1'b0;
    n = 0;
    while (!tx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("tx_pop_ready", tx_ready, 1);
    drain("fill");

    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom);
      push(b);
      rx_exp.push_back(b);
      repeat ($urandom_range(0, 30)) begin
        step();
        rx_ready = $urandom_range(0, 3) != 0;
      end
    end
    step();
    rx_ready = 1'b1;
    drain("random");

    step();
    rx_ready = 1'b0;
    for (int i = 0; i < 10; i++) bs[i] = 8'($urandom);
    for (int i = 0; i < 9; i++) rx_exp.push_back(bs[i]);
    ctl_exp.push_back({8'd1, 8'h04});
    for (int i = 0; i < 10; i++) push(bs[i]);
    n = 0;
    while (!err_overrun && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("ovr_set", err_overrun, 1);
    repeat (20) @(negedge clk);
    chk("ovr_sticky", err_overrun, 1);
    chk("ovr_no_frame", err_frame, 0);
    chk("ovr_rx_held", rx_valid, 1);
    pulse_err_clr();
    @(negedge clk);
    chk("ovr_cleared", err_overrun, 0);
    step();
    rx_ready = 1'b1;
    drain("overrun");

    frc_ph = 1'b1;
    ctl_exp.push_back({8'd1, 8'h08});
    rx_exp.push_back(8'h3C);
    step();
    inj = 1'b1;
    inj_b = 8'h3C;
    step();
    inj = 1'b0;
    drain("frame");
    chk("frame_set", err_frame, 1);
    chk("frame_no_ovr", err_overrun, 0);
    frc_ph = 1'b0;
    pulse_err_clr();
    @(negedge clk);
    chk("frame_cleared", err_frame, 0);

    push(8'h77);
    rx_exp.push_back(8'h77);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(wr_any && bus_addr == BASE) && n < 200);
    chk("txwr_seen", wr_any && bus_addr == BASE, 1);
    cfg_reinit = 1'b1;
    cfg_bauddiv = 16'd5;
    cfg_loopback = 1'b1;
    ctl_exp.push_back({8'd2, 8'h05});
    ctl_exp.push_back({8'd3, 8'h00});
    ctl_exp.push_back({8'd4, 8'h1F});
    step();
    cfg_reinit = 1'b0;
    @(negedge clk);
    chk("reinit_next_acc", {bus_as_l, bus_we_l, bus_addr},
        {2'b00, BASE + 32'd2});
    chk("reinit_done_low", init_done, 0);
    wait_init("txwr");
    drain("txwr");

    step();
    blk = 1'b1;
    push(8'hE1);
    push(8'hE2);
    step();
    cfg_reinit = 1'b1;
    cfg_bauddiv = 16'd7;
    ctl_exp.push_back({8'd2, 8'h07});
    step();
    cfg_reinit = 1'b0;
    step();
    reset_n = 1'b0;
    #1;
    chk("arst_as_l", bus_as_l, 1);
    chk("arst_we_l", bus_we_l, 1);
    chk("arst_addr", bus_addr, BASE);
    chk("arst_wdata", bus_wdata, 0);
    chk("arst_tx_ready", tx_ready, 1);
    chk("arst_rx_valid", rx_valid, 0);
    chk("arst_bl_seen", ctl_exp.size(), 0);
    tx_exp.delete();
    ctl_exp.delete();
    ctl_exp.push_back({8'd2, 8'hB1});
    ctl_exp.push_back({8'd3, 8'h01});
    ctl_exp.push_back({8'd4, 8'h1B});
    blk = 1'b0;
    step();
    reset_n = 1'b1;
    wait_init("post_rst");
    repeat (60) @(negedge clk);
    chk("end_ctl_q", ctl_exp.size(), 0);
    chk("end_err", {err_overrun, err_frame}, 0);
    chk("end_rx_valid", rx_valid, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
